flash_arbiter: RTL

Shares the single SPI flash read engine between the instruction-cache and data-cache miss paths. Latches one request at a time and checks its CPU flash address range (0x00000–0xAFFFF). Forwards the request to the SPI engine, then returns the 32-bit word with a one-cycle ready pulse to the requester that owns the grant. Icache has priority, bounded by an anti-starvation streak counter.

---
 rtl/flash_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one SPI flash read engine between the icache and dcache miss paths.
// Optional SPI wait watchdog is built in when FLASH_ARB_TIMEOUT_EN is defined.
module flash_arbiter #(
    parameter int          MAX_I_STREAK   = 4,
    parameter logic [19:0] ADDR_LIMIT     = 20'hAFFFF,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        icache_req,
    input  logic [19:0] icache_addr,
    output logic        icache_ready,
    output logic [31:0] icache_data,
    output logic        icache_err,
    input  logic        dcache_req,
    input  logic [19:0] dcache_addr,
    output logic        dcache_ready,
    output logic [31:0] dcache_data,
    output logic        dcache_err,
    output logic        spi_req,
    output logic [19:0] spi_addr,
    input  logic        spi_data_ready,
    input  logic [31:0] spi_data,
    output logic        busy
);

    // state | meaning
    // IDLE  | sample requests, arbitrate, range-check the winner's address
    // ISSUE | load spi_req/spi_addr toward the engine
    // WAIT  | hold spi_req until the engine answers (or the watchdog fires)
    // RESP  | one-cycle ready pulse to the grant owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int            SW         = $clog2(MAX_I_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_I_STREAK);

    state_t        state, state_nx;
    logic [SW-1:0] streak;
    logic          owner_d;
    logic [19:0]   addr_q;
    logic          pick_d;
    logic [19:0]   sel_addr;
    logic          grant_i, grant_d;
    logic          resp_go, resp_err, resp_owner;
    logic [31:0]   resp_data;
    logic          tmo, hold;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          hold_q;

    // hold_q keeps IDLE from granting on its first cycle after a timeout,
    // so the engine always observes spi_req low between transactions.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
            hold_q  <= 1'b0;
        end else begin
            if (state == ISSUE)
                tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
            else if (state == WAIT && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TW'(1);
            if (tmo)
                hold_q <= 1'b1;
            else if (state == IDLE)
                hold_q <= 1'b0;
        end
    end

    assign tmo  = (state == WAIT) && !spi_data_ready && (tmo_cnt == '0);
    assign hold = hold_q;
`else
    assign tmo  = 1'b0;
    assign hold = 1'b0;
`endif

    assign pick_d   = dcache_req && (!icache_req || streak == STREAK_MAX);
    assign sel_addr = pick_d ? dcache_addr : icache_addr;
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        resp_go    = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        resp_owner = owner_d;
        case (state)
            IDLE: begin
                if (!hold && (icache_req || dcache_req)) begin
                    grant_d = pick_d;
                    grant_i = !pick_d;
                    if (sel_addr > ADDR_LIMIT) begin
                        state_nx   = RESP;
                        resp_go    = 1'b1;
                        resp_err   = 1'b1;
                        resp_owner = pick_d;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (spi_data_ready) begin
                    state_nx  = RESP;
                    resp_go   = 1'b1;
                    resp_data = spi_data;
                end else if (tmo) begin
                    state_nx = RESP;
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            streak       <= '0;
            owner_d      <= 1'b0;
            addr_q       <= '0;
            spi_req      <= 1'b0;
            spi_addr     <= '0;
            icache_ready <= 1'b0;
            icache_data  <= '0;
            icache_err   <= 1'b0;
            dcache_ready <= 1'b0;
            dcache_data  <= '0;
            dcache_err   <= 1'b0;
        end else begin
            icache_ready <= 1'b0;
            icache_err   <= 1'b0;
            dcache_ready <= 1'b0;
            dcache_err   <= 1'b0;

            if (grant_i || grant_d) begin
                owner_d <= grant_d;
                addr_q  <= sel_addr;
                if (grant_d || !dcache_req)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + SW'(1);
            end

            if (state == ISSUE) begin
                spi_req  <= 1'b1;
                spi_addr <= addr_q;
            end else if (state == WAIT && resp_go) begin
                spi_req <= 1'b0;
            end

            // Response flops load on entry to RESP, so ready is high exactly in RESP.
            if (resp_go) begin
                if (resp_owner) begin
                    dcache_ready <= 1'b1;
                    dcache_data  <= resp_data;
                    dcache_err   <= resp_err;
                end else begin
                    icache_ready <= 1'b1;
                    icache_data  <= resp_data;
                    icache_err   <= resp_err;
                end
            end
        end
    end

endmodule
